ladybird_csr_access: RTL

LADYBIRD_CSR_ACCESS -- requirements
Module: ladybird_csr_access

---
 rtl/ladybird_csr_access_if.sv | 45 ++++
 rtl/ladybird_csr_access.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ladybird_csr_access_if.sv
// Request, response and CSR-file signals of the CSR access unit.
// slave: the access unit's view; master: the core / CSR-file side.
interface ladybird_csr_access_if #(
    parameter int XLEN = 32
);
    // request channel
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_addr;
    logic [4:0]      req_rs1_idx;
    logic [XLEN-1:0] req_rs1_data;
    logic [4:0]      req_rd;
    // response channel
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic            resp_illegal;
    logic            retire;
    // CSR-file port
    logic            csr_valid;
    logic [2:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;

    modport slave (
        input  req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data, req_rd,
        output req_ready,
        input  resp_ready,
        output resp_valid, resp_data, resp_rd, resp_illegal, retire,
        output csr_valid, csr_op, csr_addr, csr_wdata,
        input  csr_rdata
    );

    modport master (
        output req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data, req_rd,
        input  req_ready,
        output resp_ready,
        input  resp_valid, resp_data, resp_rd, resp_illegal, retire,
        input  csr_valid, csr_op, csr_addr, csr_wdata,
        output csr_rdata
    );
endinterface

// File: rtl/ladybird_csr_access.sv
// CSR access unit: takes one CSR instruction at a time, checks privilege
// and read-only rules, drives a single write-enable cycle into the CSR file
// and returns the old CSR value. IDLE -> ACCESS -> RESP -> IDLE.
module ladybird_csr_access #(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [1:0]            priv_mode,
    input  logic                  flush,
    ladybird_csr_access_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e          state_q;
    logic            rdy_q;       // req_ready before flush gating
    logic            wr_q;        // write enable for the ACCESS cycle
    logic            ill_q;       // request judged illegal at acceptance
    logic [11:0]     addr_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic            rvld_q;
    logic [XLEN-1:0] rdata_q;
    logic [4:0]      rrd_q;
    logic            rill_q;

    logic            wr_intent;
    logic            illegal;
    logic [XLEN-1:0] operand;
    logic            acc;
    logic            resp_hs;

    // Decode the incoming request: write intent, legality and write operand.
    always_comb begin
        wr_intent = 1'b0;
        illegal   = 1'b0;
        operand   = bus.req_rs1_data;
        // RW/RWI always write; set/clear forms write only with a nonzero source
        if (bus.req_funct3[1:0] == 2'b01)
            wr_intent = 1'b1;
        else if (bus.req_funct3[1:0] != 2'b00)
            wr_intent = (bus.req_rs1_idx != 5'd0);
        if (bus.req_funct3[1:0] == 2'b00)
            illegal = 1'b1;
        if (bus.req_addr[9:8] > priv_mode)
            illegal = 1'b1;
        if ((bus.req_addr[11:10] == 2'b11) && wr_intent)
            illegal = 1'b1;
        // immediate forms carry the zimm in the rs1 index field
        if (bus.req_funct3[2])
            operand = {{(XLEN-5){1'b0}}, bus.req_rs1_idx};
    end

    // flush blocks both the request and the response handshakes that cycle
    assign acc     = bus.req_valid & rdy_q & ~flush;
    assign resp_hs = rvld_q & bus.resp_ready & ~flush;

    // Access FSM with all outputs registered; reset drops any in-flight access.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rvld_q  <= 1'b0;
            rdata_q <= '0;
            rrd_q   <= '0;
            rill_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (acc) begin
                        addr_q  <= bus.req_addr;
                        op_q    <= bus.req_funct3;
                        wdata_q <= operand;
                        rd_q    <= bus.req_rd;
                        ill_q   <= illegal;
                        wr_q    <= wr_intent & ~illegal;
                        rdy_q   <= 1'b0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    wr_q <= 1'b0;
                    if (flush) begin
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        // old value is captured for reads and writes alike
                        rdata_q <= ill_q ? '0 : bus.csr_rdata;
                        rrd_q   <= rd_q;
                        rill_q  <= ill_q;
                        rvld_q  <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (flush || resp_hs) begin
                        rvld_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    wr_q    <= 1'b0;
                    rvld_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = rdy_q & ~flush;
    assign bus.csr_valid    = wr_q & ~flush;
    assign bus.csr_op       = op_q;
    assign bus.csr_addr     = addr_q;
    assign bus.csr_wdata    = wdata_q;
    assign bus.resp_valid   = rvld_q & ~flush;
    assign bus.resp_data    = rdata_q;
    assign bus.resp_rd      = rrd_q;
    assign bus.resp_illegal = rill_q;
    assign bus.retire       = resp_hs & ~rill_q;

endmodule
